// File: rtl/mips_control_signals.sv
// rtl/mips_control_signals.sv - registered MIPS load/store/lui control decode
//
// Purpose:
//   Decodes the 6-bit instruction opcode into register-file, data-memory and
//   write-back-select controls. Every output is registered: the opcode seen at
//   rising edge N drives the outputs from edge N until edge N+1. There is no
//   combinational path from opcode to any output and no opcode history.
//
// Ports:
//   clk        in   1  block clock, all state updates on the rising edge
//   reset      in   1  synchronous active-high reset; forces all outputs to 0
//   opcode     in   6  instruction bits [31:26]
//   RegWrite   out  1  register-file write enable
//   MemRead    out  1  data-memory read enable
//   MemWrite   out  1  data-memory write enable
//   luiSign    out  1  selects (imm << 16) as the write-back source
//   select2    out  1  SEL[2] of the load/store size select {select2,select1,select0}
//   select1    out  1  SEL[1]
//   select0    out  1  SEL[0]
//   illegal_op out  1  only with MIPS_CTRL_ILLEGAL_FLAG_EN defined; 1 while the
//                      registered opcode is not a recognised instruction
//
// Configuration macro: MIPS_CTRL_ILLEGAL_FLAG_EN

module mips_control_signals (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       luiSign,
  output logic       select2,
  output logic       select1,
`ifdef MIPS_CTRL_ILLEGAL_FLAG_EN
  output logic       select0,
  output logic       illegal_op
`else
  output logic       select0
`endif
);

  // Opcode encodings handled by this decoder.
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LUI = 6'b001111;

  // Load/store size select codes.
  localparam logic [2:0] SEL_W   = 3'b000;
  localparam logic [2:0] SEL_B   = 3'b001;
  localparam logic [2:0] SEL_BU  = 3'b010;
  localparam logic [2:0] SEL_H   = 3'b011;
  localparam logic [2:0] SEL_HU  = 3'b100;
  localparam logic [2:0] SEL_SB  = 3'b101;
  localparam logic [2:0] SEL_SH  = 3'b110;
  localparam logic [2:0] SEL_LUI = 3'b111;

  logic       regwrite_d, regwrite_q;
  logic       memread_d,  memread_q;
  logic       memwrite_d, memwrite_q;
  logic       luisign_d,  luisign_q;
  logic [2:0] sel_d,      sel_q;
  logic       illegal_d,  illegal_q;

  // Next-state decode. Unlisted opcodes fall through to the all-zero default,
  // which is a safe no-op: no register write and no memory access.
  always_comb begin
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    luisign_d  = 1'b0;
    sel_d      = SEL_W;
    illegal_d  = 1'b0;
    unique case (opcode)
      OP_LW: begin
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        sel_d      = SEL_W;
      end
      OP_LB: begin
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        sel_d      = SEL_B;
      end
      OP_LBU: begin
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        sel_d      = SEL_BU;
      end
      OP_LH: begin
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        sel_d      = SEL_H;
      end
      OP_LHU: begin
        regwrite_d = 1'b1;
        memread_d  = 1'b1;
        sel_d      = SEL_HU;
      end
      OP_SB: begin
        memwrite_d = 1'b1;
        sel_d      = SEL_SB;
      end
      OP_SH: begin
        memwrite_d = 1'b1;
        sel_d      = SEL_SH;
      end
      OP_SW: begin
        memwrite_d = 1'b1;
        sel_d      = SEL_W;
      end
      OP_LUI: begin
        // lui writes the register file from the immediate path, not memory.
        regwrite_d = 1'b1;
        luisign_d  = 1'b1;
        sel_d      = SEL_LUI;
      end
      default: begin
        illegal_d  = 1'b1;
      end
    endcase
  end

  // Reset wins over whatever opcode is present at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      luisign_q  <= 1'b0;
      sel_q      <= SEL_W;
      illegal_q  <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      luisign_q  <= luisign_d;
      sel_q      <= sel_d;
      illegal_q  <= illegal_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign MemRead  = memread_q;
  assign MemWrite = memwrite_q;
  assign luiSign  = luisign_q;
  assign select2  = sel_q[2];
  assign select1  = sel_q[1];
  assign select0  = sel_q[0];

`ifdef MIPS_CTRL_ILLEGAL_FLAG_EN
  assign illegal_op = illegal_q;
`else
  // Flag register is still built so the decode stays identical; without the
  // port it has no load and is trimmed away.
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mips_control_signals.sv
// tb/tb_mips_control_signals.sv - scoreboard bench for mips_control_signals

module tb_mips_control_signals;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       RegWrite, MemRead, MemWrite, luiSign;
  logic       select2, select1, select0;
  logic       ill_obs;

  int total = 0;
  int bad   = 0;

  // Expected word layout: {RegWrite, MemRead, MemWrite, luiSign, SEL[2:0], illegal}
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef MIPS_CTRL_ILLEGAL_FLAG_EN
  logic illegal_op;
  assign ill_obs = illegal_op;
  mips_control_signals dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .luiSign(luiSign), .select2(select2), .select1(select1),
    .select0(select0), .illegal_op(illegal_op)
  );
`else
  assign ill_obs = 1'b0;
  mips_control_signals dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .luiSign(luiSign), .select2(select2), .select1(select1),
    .select0(select0)
  );
`endif

  function automatic logic [7:0] model(input logic rst, input logic [5:0] op);
    logic [7:0] e;
    if (rst) return 8'b0000_0000;
    case (op)
      6'b100011: e = 8'b1100_000_0;
      6'b100000: e = 8'b1100_001_0;
      6'b100100: e = 8'b1100_010_0;
      6'b100001: e = 8'b1100_011_0;
      6'b100101: e = 8'b1100_100_0;
      6'b101000: e = 8'b0010_101_0;
      6'b101001: e = 8'b0010_110_0;
      6'b101011: e = 8'b0010_000_0;
      6'b001111: e = 8'b1001_111_0;
`ifdef MIPS_CTRL_ILLEGAL_FLAG_EN
      default:   e = 8'b0000_000_1;
`else
      default:   e = 8'b0000_000_0;
`endif
    endcase
    return e;
  endfunction

  function automatic logic [7:0] observed();
    return {RegWrite, MemRead, MemWrite, luiSign, select2, select1, select0, ill_obs};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one cycle: inputs applied away from the edge, expectation pushed,
  // then the registered result is popped and compared just after the edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op);
    logic [7:0] e;
    @(negedge clk);
    reset  = rst;
    opcode = op;
    exp_q.push_back(model(rst, op));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, observed(), e);
  endtask

  logic [5:0] sweep [9];
  logic [5:0] r;
  logic [7:0] o;

  initial begin
    reset  = 1'b1;
    opcode = 6'b100011;

    // Reset held with lw on the bus, then released.
    step("reset_c0", 1'b1, 6'b100011);
    step("reset_c1", 1'b1, 6'b100011);
    step("release_lw", 1'b0, 6'b100011);

    sweep = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
              6'b101000, 6'b101001, 6'b101011, 6'b001111};
    foreach (sweep[i]) step($sformatf("sweep_%b", sweep[i]), 1'b0, sweep[i]);

    step("illegal_000000", 1'b0, 6'b000000);
    step("illegal_111111", 1'b0, 6'b111111);

    step("lui_then", 1'b0, 6'b001111);
    step("sw_after_lui", 1'b0, 6'b101011);

    step("reset_over_sb", 1'b1, 6'b101000);
    step("sb_after_reset", 1'b0, 6'b101000);
    step("lw_after_sb", 1'b0, 6'b100011);

    for (int i = 0; i < 1000; i++) begin
      r = 6'($urandom_range(0, 63));
      step("random", 1'b0, r);
      o = observed();
      chk("rd_wr_exclusive", {7'b0, o[6] & o[5]}, 8'b0);
      chk("lui_implies_sel7", {7'b0, o[4] & (o[3:1] != 3'b111)}, 8'b0);
    end

    step("final_reset", 1'b1, 6'b001111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_control_signals.md
MIPS_CONTROL_SIGNALS -- requirements
Module: mips_control_signals

Interface
REQ-001 Parameters SHALL be none; opcode decode values are fixed constants.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 opcode  input  6  instruction opcode field, bits [31:26] of the instruction.
REQ-005 RegWrite  output  1  register-file write enable.
REQ-006 MemRead  output  1  data-memory read enable.
REQ-007 MemWrite  output  1  data-memory write enable.
REQ-008 luiSign  output  1  selects the upper-immediate path (imm << 16) as the write-back source.
REQ-009 select2  output  1  bit 2 of the 3-bit load/store size select, SEL = {select2, select1, select0}.
REQ-010 select1  output  1  bit 1 of SEL.
REQ-011 select0  output  1  bit 0 of SEL.

Function
REQ-012 All outputs SHALL be registered: the opcode present at rising edge N drives the outputs from edge N until edge N+1 (1-cycle latency, no combinational path from opcode to outputs).
REQ-013 Decode table (RegWrite, MemRead, MemWrite, luiSign, SEL) SHALL be:
  - 100011 lw: 1,1,0,0,000
  - 100000 lb: 1,1,0,0,001
  - 100100 lbu: 1,1,0,0,010
  - 100001 lh: 1,1,0,0,011
  - 100101 lhu: 1,1,0,0,100
  - 101000 sb: 0,0,1,0,101
  - 101001 sh: 0,0,1,0,110
  - 101011 sw: 0,0,1,0,000
  - 001111 lui: 1,0,0,1,111
REQ-014 Any opcode not listed in REQ-013 SHALL produce 0,0,0,0,000 (no write, no memory access).
REQ-015 MemRead and MemWrite SHALL never both be 1 in the same cycle.
REQ-016 luiSign SHALL be 1 only when SEL = 111.
REQ-017 Decode SHALL depend only on the current registered opcode; there is no multi-cycle state and no opcode history.
REQ-018 X/Z on opcode SHALL NOT need defined handling; every legal 6-bit value SHALL be decoded per REQ-013/REQ-014.

Reset
REQ-019 While reset is 1 at a rising clk edge, all outputs SHALL be 0 on the following cycle (SEL = 000), regardless of opcode.
REQ-020 On the first rising edge with reset = 0, the outputs SHALL reflect the opcode sampled at that edge.
REQ-021 Asserting reset during any instruction SHALL override that instruction's decode at the same edge.

Configuration
REQ-022 Macro MIPS_CTRL_ILLEGAL_FLAG_EN, when defined, SHALL add the output illegal_op (1 bit, registered, reset value 0).
  - illegal_op SHALL be 1 exactly in the cycles where REQ-014 applies.
REQ-023 When MIPS_CTRL_ILLEGAL_FLAG_EN is undefined, the illegal_op port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 reset = 1 with opcode = 100011 for 2 cycles -> all outputs 0 on each cycle; release reset -> next edge gives 1,1,0,0,000.
REQ-025 Sweep opcodes 100000, 100100, 100001, 100101, 100011, 101000, 101001, 101011, 001111, one per cycle -> each REQ-013 row appears exactly one cycle after its opcode is applied.
REQ-026 opcode = 000000, then 111111 -> all outputs 0; illegal_op = 1 when the macro is defined.
REQ-027 opcode = 001111 followed by 101011 -> luiSign 1 then 0; SEL 111 then 000; RegWrite 1 then 0; MemWrite 0 then 1.
REQ-028 Assert reset on the edge where opcode = 101000 -> MemWrite stays 0; the next non-reset edge with opcode = 101000 gives MemWrite 1 and SEL 101.
REQ-029 Random opcodes over 1000 cycles -> MemRead and MemWrite never both 1; luiSign = 1 implies SEL = 111.
